connectn_board: RTL

Parametrised Connect-N game engine with Pop-Out support. It holds a COLS×ROWS board and applies drop and pop moves received over a valid/ready command port. After each legal move it runs a sequential win/draw scan and reports through a one-cycle response strobe. It sits between the keypad/column-select front end and the VGA renderer; the renderer reads cell contents through a combinational read port.

---
 rtl/connectn_board.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/connectn_board.sv
// connectn_board: Connect-N engine with Pop-Out moves, a sequential win/draw scan
// and a combinational cell read port for the display.
module connectn_board #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic          cmd_pop,
    input  logic [CW-1:0] cmd_col,
    output logic          cmd_ready,
    output logic          resp_valid,
    output logic [2:0]    resp_err,
    output logic          cur_player,
    output logic          game_over,
    output logic [1:0]    winner,
    output logic [7:0]    move_count,
    input  logic [CW-1:0] rd_col,
    input  logic [CW-1:0] rd_row,
    output logic          rd_occ,
    output logic          rd_owner
);
    localparam int CI = $clog2(COLS);
    localparam int RI = $clog2(ROWS);
    localparam logic [2:0] IDLE = 3'd0, APPLY = 3'd1, SCAN = 3'd2, RESP = 3'd3, OVER = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [COLS-1:0][ROWS-1:0] occ_q, occ_d, own_q, own_d;
    logic [COLS-1:0][CW-1:0]   height_q, height_d;
    logic [CW-1:0]             col_q, col_d, h;
    logic                      pop_q, pop_d, cur_q, cur_d, over_q, over_d;
    logic                      wy_q, wy_d, wr_q, wr_d;
    logic [1:0]                winner_q, winner_d, res;
    logic [7:0]                cnt_q, cnt_d;
    logic [2:0]                err_q, err_d, chk_err;
    logic [CI-1:0]             sc_q, sc_d, ci;
    logic [RI-1:0]             sr_q, sr_d;
    logic                      hit_y, hit_r, full, col_end, last, wy, wr, ok, inb, rd_in;
    int                        c, r;

    // Window test at the scan cell: up, right, up-right, down-right; off-board cells fail.
    always_comb begin
        hit_y = 1'b0;
        hit_r = 1'b0;
        ok    = 1'b0;
        inb   = 1'b0;
        c     = 0;
        r     = 0;
        for (int d = 0; d < 4; d++) begin
            ok = occ_q[sc_q][sr_q];
            for (int k = 1; k < WIN_LEN; k++) begin
                c   = int'(sc_q) + (d == 0 ? 0 : k);
                r   = int'(sr_q) + (d == 1 ? 0 : d == 3 ? -k : k);
                inb = c < COLS && r >= 0 && r < ROWS;
                ok  = ok && inb && occ_q[CI'(inb ? c : 0)][RI'(inb ? r : 0)]
                      && own_q[CI'(inb ? c : 0)][RI'(inb ? r : 0)] == own_q[sc_q][sr_q];
            end
            hit_y = hit_y | (ok & ~own_q[sc_q][sr_q]);
            hit_r = hit_r | (ok & own_q[sc_q][sr_q]);
        end
    end

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        own_d    = own_q;
        height_d = height_q;
        col_d    = col_q;
        pop_d    = pop_q;
        cur_d    = cur_q;
        over_d   = over_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sc_d     = sc_q;
        sr_d     = sr_q;
        wy_d     = wy_q;
        wr_d     = wr_q;
        ci       = CI'(col_q);
        h        = height_q[ci];
        chk_err  = over_q ? 3'd4 : int'(col_q) >= COLS ? 3'd1 : !pop_q && int'(h) == ROWS ? 3'd2
                 : pop_q && (h == '0 || own_q[ci][0] != cur_q) ? 3'd3 : 3'd0;
        full = 1'b1;
        for (int i = 0; i < COLS; i++) full = full && int'(height_q[i]) == ROWS;
        wy      = wy_q | hit_y;
        wr      = wr_q | hit_r;
        col_end = sr_q == RI'(ROWS - 1);
        last    = col_end && sc_q == CI'(COLS - 1);
        res     = wy && wr ? {cur_q, ~cur_q} : wr ? 2'b10 : wy ? 2'b01 : full ? 2'b11 : 2'b00;
        case (state_q)
            IDLE, OVER: if (cmd_valid) begin
                state_d = APPLY;
                col_d   = cmd_col;
                pop_d   = cmd_pop;
            end
            APPLY: begin
                err_d   = chk_err;
                state_d = chk_err != 3'd0 ? RESP : SCAN;
                sc_d    = '0;
                sr_d    = '0;
                wy_d    = 1'b0;
                wr_d    = 1'b0;
                if (chk_err == 3'd0) begin
                    cnt_d = cnt_q + 8'(cnt_q != 8'hFF);
                    // Cells above the height are empty, so a whole-column shift is the pop.
                    if (pop_q) begin
                        occ_d[ci]    = occ_q[ci] >> 1;
                        own_d[ci]    = own_q[ci] >> 1;
                        height_d[ci] = h - CW'(1);
                    end else begin
                        occ_d[ci][RI'(h)] = 1'b1;
                        own_d[ci][RI'(h)] = cur_q;
                        height_d[ci]      = h + CW'(1);
                    end
                end
            end
            SCAN: begin
                wy_d = wy;
                wr_d = wr;
                sr_d = col_end ? '0 : sr_q + RI'(1);
                sc_d = col_end ? sc_q + CI'(1) : sc_q;
                if (last) begin
                    state_d  = RESP;
                    winner_d = res;
                    over_d   = res != 2'b00;
                    cur_d    = res == 2'b00 ? ~cur_q : cur_q;
                end
            end
            RESP:    state_d = over_q ? OVER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            occ_q    <= '0;
            own_q    <= '0;
            height_q <= '0;
            col_q    <= '0;
            pop_q    <= 1'b0;
            cur_q    <= 1'b1;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
            cnt_q    <= 8'd0;
            err_q    <= 3'd0;
            sc_q     <= '0;
            sr_q     <= '0;
            wy_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            own_q    <= own_d;
            height_q <= height_d;
            col_q    <= col_d;
            pop_q    <= pop_d;
            cur_q    <= cur_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sc_q     <= sc_d;
            sr_q     <= sr_d;
            wy_q     <= wy_d;
            wr_q     <= wr_d;
        end
    end

    assign cmd_ready  = state_q == IDLE || state_q == OVER;
    assign resp_valid = state_q == RESP;
    assign resp_err   = err_q;
    assign cur_player = cur_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign move_count = cnt_q;
    assign rd_in      = int'(rd_col) < COLS && int'(rd_row) < ROWS;
    assign rd_occ     = rd_in && occ_q[CI'(rd_col)][RI'(rd_row)];
    assign rd_owner   = rd_in && own_q[CI'(rd_col)][RI'(rd_row)];
endmodule
